bayer2rgb_cfg: RTL and testbench
================================

// Module: bayer2rgb_cfg
// PURPOSE
//  Parametrised bilinear demosaic: Bayer stream (DW bits/pixel) in, RGB (3*DW) out. Sits between sensor capture and the RGB pipeline.
//  Adds four things to the fixed-8-bit GBRG converter:
//   - runtime-selectable CFA pattern, latched per frame
//   - mirrored edge handling
//   - per-frame row/col reset on vsync
//   - pixel-exact fixed latency
// PARAMETERS
//  DW       8     Bayer and per-channel RGB width (8..14)
//  H_DISP   640   active pixels per line (even, >=4)
//  V_DISP   480   active lines per frame (even, >=4)
//  CW       12    row/col counter width; 2**CW > max(H_DISP,V_DISP)
// PORTS
//  clk           in   1     pixel clock; single clock domain
//  rst_n         in   1     reset: synchronous, active-low
//  cfa_sel       in   2     0=RGGB 1=GRBG 2=GBRG 3=BGGR; sampled only at vsync rising edge
//  bayer_vsync   in   1     frame sync, active high
//  bayer_hsync   in   1     line sync
//  bayer_de      in   1     pixel valid
//  bayer_data    in   DW    Bayer sample
//  rgb_vsync     out  1     bayer_vsync delayed LAT
//  rgb_hsync     out  1     bayer_hsync delayed LAT
//  rgb_de        out  1     bayer_de delayed LAT
//  rgb_data      out  3*DW  {R,G,B}, valid when rgb_de
//  cfa_active    out  2     pattern in use for the current frame
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, cfa_active=0, counters 0, delay lines cleared; line-buffer RAM contents are don't-care.
//  LAT = 3 clk, fixed: window (1) + tap select/mirror (1) + interpolate/register (1).
//   rgb_de/hsync/vsync are the inputs delayed exactly 3 clk.
//  Counters:
//   - col: increments on each de cycle; wraps H_DISP-1 -> 0 and increments row.
//   - row: wraps V_DISP-1 -> 0.
//   - vsync rising edge forces row=col=0; same-cycle de is counted as pixel (0,0).
//   - cfa_active <= cfa_sel on that same edge. A mid-frame cfa_sel change has no effect until the next frame.
//  Window: two line buffers, H_DISP x DW each, written only on de. Taps are rows r-2..r, cols c-2..c.
//   The output centre is pixel (r-1,c-1), so output position (y,x) carries the demosaic of input (y-1,x-1).
//   Output row 0 and output column 0 are emitted as RGB=0 with de still high.
//  Edge mirror (centre on the last row/col or row/col 0): a tap outside the frame at index -1 uses index +1, and index N uses N-2. This preserves Bayer phase.
//  Site phase p = {centre_row[0], centre_col[0]} XOR pattern offset:
//   RGGB=00, GRBG=01, GBRG=10, BGGR=11.
//   Phase 00=R site, 01=G in R row, 10=G in B row, 11=B site.
//  Interpolation at each site:
//   R site : R = centre; G = (N+S+E+W)>>2; B = (NE+NW+SE+SW)>>2
//   B site : B = centre; G = (N+S+E+W)>>2; R = (NE+NW+SE+SW)>>2
//   G, R row: G = centre; R = (E+W)>>1; B = (N+S)>>1
//   G, B row: G = centre; B = (E+W)>>1; R = (N+S)>>1
//  Arithmetic: sums in DW+2 bits, truncating shift. No rounding and no clamp needed (result <= 2**DW-1).
//  de low: counters and line buffers hold; rgb_data holds its last value.
//  Reset mid-frame: the pipeline flushes. The frame is garbage until the next vsync rising edge, and cfa_active is 0 until then.
//  Frame with fewer than V_DISP lines: counters resynchronise on the next vsync with no lockup.
// STRUCTURE
//  Package bayer_pkg holds:
//   - the cfa_e enum {CFA_RGGB, CFA_GRBG, CFA_GBRG, CFA_BGGR}
//   - the phase offset table and the site_e enum
//  Sub-module bayer_window3x3 (DW, H_DISP): line buffers, 3x3 tap registers and row/col counters. Outputs the 9 taps, centre coords and tap valid.
//  Top level: mirror mux, phase decode, interpolation, sync delay lines.
// TESTING
//  1. Flat frame, all samples 0x80, each cfa_sel -> every rgb_data = 0x808080 except the row-0/col-0 border, which is 0.
//  2. RGGB, R=200, G=100, B=50 sites, 8x8 frame -> interior pixels all {200,100,50}; R-site G = 100 exactly.
//  3. Ramp bayer_data = col, GBRG -> horizontal averages exact (e.g. R at a G site between cols 3 and 5 = 4); edge col H-1 mirrored.
//  4. Change cfa_sel mid-frame RGGB->BGGR -> cfa_active stays 0 until the next vsync rise, then 3.
//  5. Random de gaps (30% idle) vs gap-free reference -> identical rgb_data sequence on de; rgb_de = bayer_de delayed 3.
//  6. Assert rst_n low for 1 clk mid-line -> outputs 0 next cycle; next full frame matches the model bit-exactly.

Source files
------------

// File: rtl/bayer2rgb_cfg_pkg.sv
// Shared types for the configurable Bayer-to-RGB demosaic: CFA pattern, site kind, phase lookup.
package bayer_pkg;

  typedef enum logic [1:0] {
    CFA_RGGB = 2'd0,
    CFA_GRBG = 2'd1,
    CFA_GBRG = 2'd2,
    CFA_BGGR = 2'd3
  } cfa_e;

  typedef enum logic [1:0] {
    SiteR  = 2'b00,
    SiteGr = 2'b01,
    SiteGb = 2'b10,
    SiteB  = 2'b11
  } site_e;

  // Phase offset of each pattern relative to an RGGB grid.
  function automatic logic [1:0] cfa_offset(input cfa_e cfa);
    logic [1:0] off;
    unique case (cfa)
      CFA_RGGB: off = 2'b00;
      CFA_GRBG: off = 2'b01;
      CFA_GBRG: off = 2'b10;
      CFA_BGGR: off = 2'b11;
    endcase
    return off;
  endfunction

  function automatic site_e site_of(input logic row_lsb, input logic col_lsb, input cfa_e cfa);
    return site_e'({row_lsb, col_lsb} ^ cfa_offset(cfa));
  endfunction

endpackage

// File: rtl/bayer2rgb_cfg_if.sv
// Raster video stream: frame/line syncs, pixel valid and one data word per pixel.
interface bayer2rgb_cfg_if #(
  parameter int unsigned W = 8
) ();
  logic         vsync;
  logic         hsync;
  logic         de;
  logic [W-1:0] data;

  modport master (output vsync, hsync, de, data);
  modport slave  (input  vsync, hsync, de, data);
endinterface

// File: rtl/bayer2rgb_cfg_window3x3.sv
// Two line buffers plus a 3x3 tap array and the row/col raster counters; advances only on de.
module bayer_window3x3 #(
  parameter int unsigned DW     = 8,
  parameter int unsigned H_DISP = 640,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned CW     = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vsync,
  input  logic                     de,
  input  logic [DW-1:0]            data,
  output logic                     sof,
  output logic [2:0][2:0][DW-1:0]  taps,
  output logic [CW-1:0]            ctr_row,
  output logic [CW-1:0]            ctr_col,
  output logic                     border,
  output logic                     tap_valid
);

  localparam int unsigned AW = $clog2(H_DISP);

  logic          vsync_q;
  logic [CW-1:0] row_q, col_q, row_cur, col_cur, row_d, col_d;
  logic [DW-1:0] lb1 [H_DISP];
  logic [DW-1:0] lb2 [H_DISP];
  logic [DW-1:0] lb1_rd, lb2_rd;
  logic [AW-1:0] idx;

  assign sof    = vsync & ~vsync_q;
  assign idx    = col_cur[AW-1:0];
  assign lb1_rd = lb1[idx];
  assign lb2_rd = lb2[idx];

  // A de on the vsync rising edge is already pixel (0,0).
  always_comb begin
    row_cur = sof ? '0 : row_q;
    col_cur = sof ? '0 : col_q;
    row_d   = row_cur;
    col_d   = col_cur;
    if (de) begin
      if (col_cur == CW'(H_DISP - 1)) begin
        col_d = '0;
        row_d = (row_cur == CW'(V_DISP - 1)) ? '0 : row_cur + CW'(1);
      end else begin
        col_d = col_cur + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (de) begin
      lb1[idx] <= data;
      lb2[idx] <= lb1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      taps      <= '0;
      ctr_row   <= '0;
      ctr_col   <= '0;
      border    <= 1'b0;
      tap_valid <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      row_q     <= row_d;
      col_q     <= col_d;
      tap_valid <= de;
      if (de) begin
        for (int r = 0; r < 3; r++) begin
          taps[r][0] <= taps[r][1];
          taps[r][1] <= taps[r][2];
        end
        taps[0][2] <= lb2_rd;
        taps[1][2] <= lb1_rd;
        taps[2][2] <= data;
        ctr_row    <= row_cur - CW'(1);
        ctr_col    <= col_cur - CW'(1);
        border     <= (row_cur == '0) || (col_cur == '0);
      end
    end
  end

endmodule

// File: rtl/bayer2rgb_cfg.sv
// Bilinear Bayer demosaic with per-frame CFA selection, mirrored edges and a fixed 3-clock latency.
module bayer2rgb_cfg
  import bayer_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned H_DISP = 640,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned CW     = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cfa_sel,
  bayer2rgb_cfg_if.slave         bayer,
  bayer2rgb_cfg_if.master        rgb,
  output logic [1:0]             cfa_active
);

  logic                    sof, tap_valid, border;
  logic [2:0][2:0][DW-1:0] taps;
  logic [CW-1:0]           ctr_row, ctr_col;
  cfa_e                    cfa_active_q, cfa_pix_q;

  bayer_window3x3 #(
    .DW    (DW),
    .H_DISP(H_DISP),
    .V_DISP(V_DISP),
    .CW    (CW)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (bayer.vsync),
    .de       (bayer.de),
    .data     (bayer.data),
    .sof      (sof),
    .taps     (taps),
    .ctr_row  (ctr_row),
    .ctr_col  (ctr_col),
    .border   (border),
    .tap_valid(tap_valid)
  );

  // cfa_pix_q travels with the taps so the first pixel of a frame sees the new pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfa_active_q <= CFA_RGGB;
      cfa_pix_q    <= CFA_RGGB;
    end else begin
      if (sof) cfa_active_q <= cfa_e'(cfa_sel);
      if (bayer.de) cfa_pix_q <= sof ? cfa_e'(cfa_sel) : cfa_active_q;
    end
  end

  assign cfa_active = cfa_active_q;

  // Tap select with mirroring: an out-of-frame neighbour is replaced by the opposite one.
  logic [1:0] ri_n, ri_s, ci_w, ci_e;
  always_comb begin
    ri_n = (ctr_row == '0)                ? 2'd2 : 2'd0;
    ri_s = (ctr_row == CW'(V_DISP - 1))   ? 2'd0 : 2'd2;
    ci_w = (ctr_col == '0)                ? 2'd2 : 2'd0;
    ci_e = (ctr_col == CW'(H_DISP - 1))   ? 2'd0 : 2'd2;
  end

  logic [DW-1:0] n_q, s_q, e_q, w_q, ne_q, nw_q, se_q, sw_q, c_q;
  site_e         site_q;
  logic          zero_q, v2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {n_q, s_q, e_q, w_q, ne_q, nw_q, se_q, sw_q, c_q} <= '0;
      site_q <= SiteR;
      zero_q <= 1'b0;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= tap_valid;
      if (tap_valid) begin
        c_q    <= taps[1][1];
        n_q    <= taps[ri_n][1];
        s_q    <= taps[ri_s][1];
        w_q    <= taps[1][ci_w];
        e_q    <= taps[1][ci_e];
        nw_q   <= taps[ri_n][ci_w];
        ne_q   <= taps[ri_n][ci_e];
        sw_q   <= taps[ri_s][ci_w];
        se_q   <= taps[ri_s][ci_e];
        site_q <= site_of(ctr_row[0], ctr_col[0], cfa_pix_q);
        zero_q <= border;
      end
    end
  end

  logic [DW+1:0] sum_plus, sum_x, sum_h, sum_v;
  logic [DW-1:0] r_d, g_d, b_d;

  always_comb begin
    sum_plus = (DW+2)'(n_q) + (DW+2)'(s_q) + (DW+2)'(e_q) + (DW+2)'(w_q);
    sum_x    = (DW+2)'(ne_q) + (DW+2)'(nw_q) + (DW+2)'(se_q) + (DW+2)'(sw_q);
    sum_h    = (DW+2)'(e_q) + (DW+2)'(w_q);
    sum_v    = (DW+2)'(n_q) + (DW+2)'(s_q);
    r_d      = c_q;
    g_d      = c_q;
    b_d      = c_q;
    unique case (site_q)
      SiteR: begin
        g_d = sum_plus[DW+1:2];
        b_d = sum_x[DW+1:2];
      end
      SiteB: begin
        g_d = sum_plus[DW+1:2];
        r_d = sum_x[DW+1:2];
      end
      SiteGr: begin
        r_d = sum_h[DW:1];
        b_d = sum_v[DW:1];
      end
      SiteGb: begin
        b_d = sum_h[DW:1];
        r_d = sum_v[DW:1];
      end
    endcase
  end

  logic [3*DW-1:0] rgb_q;
  logic [2:0][2:0] sync_q;  // {vsync, hsync, de} per stage

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      sync_q <= '0;
    end else begin
      sync_q[0] <= {bayer.vsync, bayer.hsync, bayer.de};
      sync_q[1] <= sync_q[0];
      sync_q[2] <= sync_q[1];
      if (v2_q) rgb_q <= zero_q ? '0 : {r_d, g_d, b_d};
    end
  end

  assign rgb.vsync = sync_q[2][2];
  assign rgb.hsync = sync_q[2][1];
  assign rgb.de    = sync_q[2][0];
  assign rgb.data  = rgb_q;

endmodule

// File: tb/tb_bayer2rgb_cfg.sv
// Frame-level bench: table of frames, image model with mirrored bilinear demosaic, sync delay check.
module tb_bayer2rgb_cfg;

  localparam int DW = 8;
  localparam int H  = 8;
  localparam int V  = 8;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cfa_sel = 2'd0;
  logic [1:0] cfa_active;

  bayer2rgb_cfg_if #(.W(DW))   bay ();
  bayer2rgb_cfg_if #(.W(3*DW)) rgb ();

  bayer2rgb_cfg #(
    .DW    (DW),
    .H_DISP(H),
    .V_DISP(V),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfa_sel   (cfa_sel),
    .bayer     (bay),
    .rgb       (rgb),
    .cfa_active(cfa_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cfa;
    int          kind;     // 0 flat 0x80, 1 RGGB sites, 2 column ramp, 3 random
    int          gap;      // idle percentage between pixels
    int          mid_cfa;  // -1: none, else cfa_sel written mid-frame
    bit          use_const;
    logic [23:0] exp_int;  // expected interior value when use_const
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  int          img [V][H];
  logic [23:0] exp_q [$];
  logic [2:0]  hist [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mir(input int i, input int n);
    if (i < 0) return -i;
    if (i >= n) return 2 * n - 2 - i;
    return i;
  endfunction

  function automatic int px(input int y, input int x);
    return img[mir(y, V)][mir(x, H)];
  endfunction

  // Output position (y,x) carries the demosaic centred on input (y-1,x-1).
  function automatic logic [23:0] model(input int y, input int x, input int cfa);
    int cy, cx, ph, c, n, s, e, w, ne, nw, se, sw, r, g, b;
    if (y == 0 || x == 0) return 24'h0;
    cy = y - 1;
    cx = x - 1;
    c  = px(cy, cx);
    n  = px(cy - 1, cx);     s  = px(cy + 1, cx);
    w  = px(cy, cx - 1);     e  = px(cy, cx + 1);
    nw = px(cy - 1, cx - 1); ne = px(cy - 1, cx + 1);
    sw = px(cy + 1, cx - 1); se = px(cy + 1, cx + 1);
    ph = (((cy % 2) << 1) | (cx % 2)) ^ cfa;
    case (ph)
      0:       begin r = c; g = (n + s + e + w) / 4; b = (ne + nw + se + sw) / 4; end
      3:       begin b = c; g = (n + s + e + w) / 4; r = (ne + nw + se + sw) / 4; end
      1:       begin g = c; r = (e + w) / 2; b = (n + s) / 2; end
      default: begin g = c; b = (e + w) / 2; r = (n + s) / 2; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic vec_t mk(input int cfa, input int kind, input int gap, input int mid_cfa,
                              input bit use_const, input logic [23:0] exp_int);
    vec_t v;
    v.cfa = cfa; v.kind = kind; v.gap = gap; v.mid_cfa = mid_cfa;
    v.use_const = use_const; v.exp_int = exp_int;
    return v;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, return just after the next rising edge.
  task automatic cyc(input logic vs, input logic hs, input logic de, input logic [DW-1:0] d);
    logic [23:0] e;
    bay.vsync = vs;
    bay.hsync = hs;
    bay.de    = de;
    bay.data  = d;
    @(negedge clk);
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {vs, hs, de};
    if (chk_en) begin
      chk("sync_delay3", 32'({rgb.vsync, rgb.hsync, rgb.de}), 32'(hist[3]));
      if (rgb.de) begin
        if (exp_q.size() == 0) begin
          chk("rgb_de_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rgb_data", 32'(rgb.data), 32'(e));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'($urandom_range(255)));
  endtask

  task automatic fill(input int kind);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        case (kind)
          0: img[y][x] = 128;
          1: img[y][x] = ((y % 2) == 0 && (x % 2) == 0) ? 200 :
                         ((y % 2) == 1 && (x % 2) == 1) ? 50 : 100;
          2: img[y][x] = x;
          default: img[y][x] = int'($urandom_range(255));
        endcase
      end
    end
  endtask

  task automatic send_frame(input vec_t v);
    fill(v.kind);
    cfa_sel = 2'(v.cfa);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("cfa_active_latched", 32'(cfa_active), 32'(v.cfa));
    for (int y = 0; y < V; y++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      for (int x = 0; x < H; x++) begin
        while (int'($urandom_range(99)) < v.gap) cyc(1'b0, 1'b0, 1'b0, 8'($urandom_range(255)));
        if (v.use_const) exp_q.push_back((y == 0 || x == 0) ? 24'h0 : v.exp_int);
        else             exp_q.push_back(model(y, x, v.cfa));
        cyc(1'b0, 1'b0, 1'b1, 8'(img[y][x]));
        if (v.mid_cfa >= 0 && y == V / 2 && x == 0) cfa_sel = 2'(v.mid_cfa);
      end
      idle(2);
    end
    idle(4);
    if (v.mid_cfa >= 0) chk("cfa_active_hold_midframe", 32'(cfa_active), 32'(v.cfa));
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = mk(0, 0, 0,  -1, 1'b1, 24'h808080);
    vecs[1] = mk(1, 0, 0,  -1, 1'b1, 24'h808080);
    vecs[2] = mk(2, 0, 0,  -1, 1'b1, 24'h808080);
    vecs[3] = mk(3, 0, 0,  -1, 1'b1, 24'h808080);
    vecs[4] = mk(0, 1, 0,  -1, 1'b1, 24'hC86432);
    vecs[5] = mk(2, 2, 0,  -1, 1'b0, 24'h0);
    vecs[6] = mk(1, 3, 30, -1, 1'b0, 24'h0);
    vecs[7] = mk(0, 3, 0,  3,  1'b0, 24'h0);
    vecs[8] = mk(3, 3, 30, -1, 1'b0, 24'h0);
    vecs[9] = mk(2, 2, 30, -1, 1'b0, 24'h0);
    for (int i = 0; i < 4; i++) hist[i] = 3'b000;

    // Reset state
    rst_n = 1'b0;
    idle(3);
    chk("reset_rgb_de",     32'(rgb.de),     32'(0));
    chk("reset_rgb_vsync",  32'(rgb.vsync),  32'(0));
    chk("reset_rgb_hsync",  32'(rgb.hsync),  32'(0));
    chk("reset_rgb_data",   32'(rgb.data),   32'(0));
    chk("reset_cfa_active", 32'(cfa_active), 32'(0));
    rst_n = 1'b1;
    idle(4);
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) send_frame(vecs[i]);

    // Reset for one clock in the middle of a line of a partially sent frame
    chk_en  = 1'b0;
    cfa_sel = 2'd2;
    fill(3);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < H + 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom_range(1, 255)));
    chk("pre_reset_cfa_active", 32'(cfa_active), 32'(2));
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("midreset_rgb_de",     32'(rgb.de),     32'(0));
    chk("midreset_rgb_data",   32'(rgb.data),   32'(0));
    chk("midreset_cfa_active", 32'(cfa_active), 32'(0));
    rst_n = 1'b1;
    exp_q.delete();
    idle(5);
    chk_en = 1'b1;
    send_frame(mk(2, 3, 30, -1, 1'b0, 24'h0));

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
